// File: rtl/lane_queue_tracker.sv
// Per-lane waiting-car counters: arrivals count up; green lanes discharge after a start-up delay at a fixed headway.
// Optional macro LANE_QUEUE_STATS_EN adds per-lane cumulative served-car counters.
module lane_queue_tracker #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned START_DELAY   = 2,
  parameter int unsigned DEPART_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           arrive,
  input  logic [7:0]           green,
  input  logic                 clr_ovf,
  output logic [8*WIDTH-1:0]   lane,
  output logic [7:0]           departed,
  output logic [7:0]           overflow
`ifdef LANE_QUEUE_STATS_EN
  ,
  output logic [8*16-1:0]      served
`endif
);

  localparam int unsigned NLANE = 8;
  localparam int unsigned TW    = 4;
  localparam int unsigned SW    = 16;
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [TW-1:0]    D_START   = TW'(START_DELAY);
  localparam logic [TW-1:0]    P_LAST    = TW'(DEPART_PERIOD - 1);

  logic [NLANE-1:0][WIDTH-1:0] r_lane;
  logic [NLANE-1:0][TW-1:0]    r_d;
  logic [NLANE-1:0][TW-1:0]    r_p;
  logic [NLANE-1:0]            r_green_q;
  logic [NLANE-1:0]            r_departed;
  logic [NLANE-1:0]            r_overflow;

  logic [NLANE-1:0][WIDTH-1:0] w_lane_nxt;
  logic [NLANE-1:0][TW-1:0]    w_d_nxt;
  logic [NLANE-1:0][TW-1:0]    w_p_nxt;
  logic [NLANE-1:0]            w_rise;
  logic [NLANE-1:0]            w_dep_req;
  logic [NLANE-1:0]            w_dep_eff;
  logic [NLANE-1:0]            w_ovf_set;

  // Discharge timer and count update, one independent slice per lane
  always_comb begin
    w_rise     = green & ~r_green_q;
    w_lane_nxt = r_lane;
    w_d_nxt    = r_d;
    w_p_nxt    = r_p;
    w_dep_req  = '0;
    w_dep_eff  = '0;
    w_ovf_set  = '0;
    for (int i = 0; i < NLANE; i++) begin
      if (w_rise[i]) begin
        w_d_nxt[i] = D_START;
        w_p_nxt[i] = '0;
      end else if (green[i] && r_d[i] != '0) begin
        w_d_nxt[i] = r_d[i] - TW'(1);
      end else if (green[i]) begin
        if (r_p[i] == P_LAST) begin
          w_p_nxt[i]   = '0;
          w_dep_req[i] = 1'b1;
        end else begin
          w_p_nxt[i] = r_p[i] + TW'(1);
        end
      end else begin
        w_d_nxt[i] = '0;
        w_p_nxt[i] = '0;
      end

      // A car arriving this cycle cannot be the one that leaves
      w_dep_eff[i] = w_dep_req[i] && (r_lane[i] != '0);

      if (arrive[i] && !w_dep_eff[i]) begin
        if (r_lane[i] == CNT_MAX) w_ovf_set[i] = 1'b1;
        else                      w_lane_nxt[i] = r_lane[i] + WIDTH'(1);
      end else if (!arrive[i] && w_dep_eff[i]) begin
        w_lane_nxt[i] = r_lane[i] - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane     <= '0;
      r_d        <= '0;
      r_p        <= '0;
      r_green_q  <= '0;
      r_departed <= '0;
      r_overflow <= '0;
    end else begin
      r_lane     <= w_lane_nxt;
      r_d        <= w_d_nxt;
      r_p        <= w_p_nxt;
      r_green_q  <= green;
      r_departed <= w_dep_eff;
      // Set wins over a same-cycle clear
      r_overflow <= (r_overflow & ~{NLANE{clr_ovf}}) | w_ovf_set;
    end
  end

  assign lane     = r_lane;
  assign departed = r_departed;
  assign overflow = r_overflow;

`ifdef LANE_QUEUE_STATS_EN
  logic [NLANE-1:0][SW-1:0] r_served;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_served <= '0;
    end else begin
      for (int i = 0; i < NLANE; i++) begin
        r_served[i] <= r_served[i] + SW'(w_dep_eff[i]);
      end
    end
  end

  assign served = r_served;
`endif

endmodule

// File: tb/tb_lane_queue_tracker.sv
// Directed testbench for lane_queue_tracker with hand-computed expectations.
module tb_lane_queue_tracker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  arrive;
  logic [7:0]  green;
  logic        clr_ovf;
  logic [63:0] lane;
  logic [7:0]  departed;
  logic [7:0]  overflow;
`ifdef LANE_QUEUE_STATS_EN
  logic [127:0] served;
`endif

  int checks = 0;
  int errors = 0;

  lane_queue_tracker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arrive   (arrive),
    .green    (green),
    .clr_ovf  (clr_ovf),
    .lane     (lane),
    .departed (departed),
    .overflow (overflow)
`ifdef LANE_QUEUE_STATS_EN
    ,
    .served   (served)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane_of(input int i);
    return lane[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arrive  = 8'h00;
    green   = 8'h00;
    clr_ovf = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    arrive = 8'h00; green = 8'h00; clr_ovf = 1'b0; rst_n = 1'b0;
    tick();
    checks++;
    if ({lane, departed, overflow} !== 80'h0) begin
      errors++;
      $display("FAIL reset_state: lane=%h departed=%h overflow=%h, expected all 0", lane, departed, overflow);
    end
    rst_n = 1'b1;
    arrive = 8'hFF;
    repeat (3) tick();
    checks++;
    if (lane !== 64'h0303_0303_0303_0303) begin
      errors++;
      $display("FAIL pre_reset_counts: lane=%h expected 0303030303030303", lane);
    end
    #2;
    rst_n = 1'b0;
    arrive = 8'h00;
    #1;
    checks++;
    if ({lane, departed, overflow} !== 80'h0) begin
      errors++;
      $display("FAIL async_reset: lane=%h departed=%h overflow=%h, expected all 0", lane, departed, overflow);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (lane !== 64'h0) begin
      errors++;
      $display("FAIL post_reset_idle: lane=%h expected 0", lane);
    end
  endtask

  task automatic test_arrivals();
    do_reset();
    arrive = 8'h04;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (departed !== 8'h00) begin
        errors++;
        $display("FAIL arrivals_departed t=%0d: departed=%h expected 00", t, departed);
      end
    end
    arrive = 8'h00;
    tick();
    checks++;
    if (lane !== 64'h0000_0000_0005_0000) begin
      errors++;
      $display("FAIL arrivals_lane2: lane=%h expected 0000000000050000", lane);
    end
  endtask

  task automatic test_discharge();
    logic [7:0] exp_lane;
    logic [7:0] exp_dep;
    do_reset();
    arrive = 8'h01;
    repeat (3) tick();
    arrive = 8'h00;
    green  = 8'h03;
    for (int t = 0; t < 20; t++) begin
      tick();
      exp_dep  = (t == 6 || t == 10 || t == 14) ? 8'h01 : 8'h00;
      exp_lane = (t < 6) ? 8'd3 : (t < 10) ? 8'd2 : (t < 14) ? 8'd1 : 8'd0;
      checks++;
      if (departed !== exp_dep) begin
        errors++;
        $display("FAIL discharge_departed k+%0d: departed=%h expected %h", t, departed, exp_dep);
      end
      checks++;
      if (lane_of(0) !== exp_lane || lane_of(1) !== 8'd0) begin
        errors++;
        $display("FAIL discharge_lane k+%0d: lane0=%0d lane1=%0d expected %0d and 0", t, lane_of(0), lane_of(1), exp_lane);
      end
    end
`ifdef LANE_QUEUE_STATS_EN
    checks++;
    if (served[15:0] !== 16'd3 || served[31:16] !== 16'd0) begin
      errors++;
      $display("FAIL served_count: served0=%0d served1=%0d expected 3 and 0", served[15:0], served[31:16]);
    end
`endif
    green = 8'h00;
  endtask

  task automatic test_abort();
    logic [7:0] exp_dep;
    logic [7:0] exp_lane;
    do_reset();
    arrive = 8'h10;
    repeat (4) tick();
    arrive = 8'h00;
    for (int t = 0; t < 17; t++) begin
      green = (t < 5 || t >= 8) ? 8'h10 : 8'h00;
      tick();
      exp_dep  = (t == 14) ? 8'h10 : 8'h00;
      exp_lane = (t >= 14) ? 8'd3 : 8'd4;
      checks++;
      if (departed !== exp_dep || lane_of(4) !== exp_lane) begin
        errors++;
        $display("FAIL abort k+%0d: departed=%h lane4=%0d expected %h and %0d", t, departed, lane_of(4), exp_dep, exp_lane);
      end
    end
    green = 8'h00;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_dep;
    logic [7:0] exp_lane;
    do_reset();
    arrive = 8'h40;
    tick();
    green = 8'h40;
    for (int t = 0; t < 15; t++) begin
      arrive = (t == 6 || t == 14) ? 8'h40 : 8'h00;
      tick();
      exp_dep  = (t == 6 || t == 10) ? 8'h40 : 8'h00;
      exp_lane = (t >= 10 && t < 14) ? 8'd0 : 8'd1;
      checks++;
      if (departed !== exp_dep || lane_of(6) !== exp_lane) begin
        errors++;
        $display("FAIL simultaneous k+%0d: departed=%h lane6=%0d expected %h and %0d", t, departed, lane_of(6), exp_dep, exp_lane);
      end
    end
    arrive = 8'h00;
    green  = 8'h00;
  endtask

  task automatic test_green_after_reset();
    green = 8'h01; arrive = 8'h00; clr_ovf = 1'b0; rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    arrive = 8'h01;
    for (int t = 0; t < 8; t++) begin
      tick();
      arrive = 8'h00;
      checks++;
      if (departed[0] !== (t == 6)) begin
        errors++;
        $display("FAIL green_after_reset k+%0d: departed0=%b expected %b", t, departed[0], (t == 6));
      end
    end
    green = 8'h00;
  endtask

  task automatic test_saturation();
    do_reset();
    arrive = 8'h80;
    for (int t = 0; t < 256; t++) begin
      tick();
      if (t == 254) begin
        checks++;
        if (lane_of(7) !== 8'd255 || overflow !== 8'h00) begin
          errors++;
          $display("FAIL sat_at_255: lane7=%0d overflow=%h expected 255 and 00", lane_of(7), overflow);
        end
      end
    end
    checks++;
    if (lane_of(7) !== 8'd255 || overflow !== 8'h80) begin
      errors++;
      $display("FAIL sat_overflow: lane7=%0d overflow=%h expected 255 and 80", lane_of(7), overflow);
    end
    arrive = 8'h00;
    repeat (2) tick();
    checks++;
    if (overflow !== 8'h80) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%h expected 80", overflow);
    end
    arrive  = 8'h80;
    clr_ovf = 1'b1;
    tick();
    checks++;
    if (overflow !== 8'h80 || lane_of(7) !== 8'd255) begin
      errors++;
      $display("FAIL set_wins: overflow=%h lane7=%0d expected 80 and 255", overflow, lane_of(7));
    end
    arrive = 8'h00;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 8'h00 || lane_of(7) !== 8'd255) begin
      errors++;
      $display("FAIL clr_ovf: overflow=%h lane7=%0d expected 00 and 255", overflow, lane_of(7));
    end
  endtask

  initial begin
    rst_n = 1'b0; arrive = 8'h00; green = 8'h00; clr_ovf = 1'b0;
    test_reset();
    test_arrivals();
    test_discharge();
    test_abort();
    test_simultaneous();
    test_green_after_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
